// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye object path: DMA state encoding and transfer length.
package jtpopeye_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_COPY  = 2'd2,
    ST_DRAIN = 2'd3
  } dma_state_e;

  localparam logic [9:0] DMA_LEN_DEF = 10'd512;

endpackage

// File: rtl/jtpopeye_dma.sv
// Object DMA: on each VB rise, takes the Z80 bus and copies DMA_LEN bytes from
// main RAM (0x8400 window) into the object buffer, then releases the bus.
module jtpopeye_dma
  import jtpopeye_pkg::*;
#(
  parameter logic [9:0] DMA_LEN = DMA_LEN_DEF,
  parameter int         OBJ_AW  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              VB,
  input  logic              busak_n,
  input  logic [7:0]        DD_DMA,
  output logic              busrq_n,
  output logic              dma_cs,
  output logic [9:0]        AD_DMA,
  output logic [OBJ_AW-1:0] obj_addr,
  output logic [7:0]        obj_data,
  output logic              obj_we,
  output logic              busy
);

  dma_state_e        state_q, state_d;
  logic              vbl_q, vbl_d;
  logic [9:0]        ad_q, ad_d;
  // rd_vld_q: the RAM latched an address on the previous cen, so its byte is on DD_DMA now
  logic              rd_vld_q, rd_vld_d;
  logic [OBJ_AW-1:0] rd_idx_q, rd_idx_d;

  always_comb begin
    state_d  = state_q;
    vbl_d    = vbl_q;
    ad_d     = ad_q;
    rd_vld_d = rd_vld_q;
    rd_idx_d = rd_idx_q;
    if (cen) begin
      vbl_d    = VB;
      rd_vld_d = (state_q == ST_COPY);
      if (state_q == ST_COPY) rd_idx_d = OBJ_AW'(ad_q);
      case (state_q)
        ST_IDLE:  if (VB && !vbl_q) state_d = ST_REQ;
        ST_REQ: begin
          if (!busak_n) begin
            state_d = ST_COPY;
            ad_d    = 10'd0;
          end
        end
        ST_COPY: begin
          if (ad_q == DMA_LEN - 10'd1) state_d = ST_DRAIN;
          else                         ad_d    = ad_q + 10'd1;
        end
        // first DRAIN cen carries the last write, the second one releases the bus
        ST_DRAIN: if (!rd_vld_q) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vbl_q    <= 1'b1;
      ad_q     <= 10'd0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      vbl_q    <= vbl_d;
      ad_q     <= ad_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Bus handshake outputs decode straight from the state flop, so reset frees the bus at once.
  assign busy     = (state_q != ST_IDLE);
  assign busrq_n  = ~busy;
  assign dma_cs   = (state_q == ST_COPY);
  assign AD_DMA   = ad_q;
  assign obj_addr = rd_idx_q;
  assign obj_we   = cen & rd_vld_q;
  assign obj_data = rd_vld_q ? DD_DMA : 8'd0;

endmodule
